pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit for the MIPS pipeline IF stage.
- Generalises the plain +4 PC with:
  - configurable width, reset address and exception vector;
  - stall, branch and jump redirect;
  - exception entry with EPC capture;
  - misaligned-target detection;
  - a halt/resume state machine.
- Drives the instruction-memory address and pc_plus4 to IF/ID.

Parameters:
- WIDTH, 32, PC/address width in bits (>= 8).
- RESET_ADDR, 32'h0000_0000, PC value loaded at reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception or misaligned target.
- INC, 4, PC increment per sequential fetch.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hold PC (hazard unit).
- halt_req  in  1  request transition to HALTED.
- resume  in  1  leave HALTED.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  WIDTH  branch destination.
- jump  in  1  redirect to jump_target.
- jump_target  in  WIDTH  jump destination.
- exc_req  in  1  exception request.
- pc  out  WIDTH  current fetch address.
- pc_plus4  out  WIDTH  pc + INC, combinational, wraps modulo 2^WIDTH.
- pc_valid  out  1  pc is a valid fetch this cycle.
- epc  out  WIDTH  address captured on exception entry.
- misalign_err  out  1  one-cycle pulse, redirect target not INC-aligned.
- halted  out  1  FSM in HALTED.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_ADDR, epc=0, misalign_err=0, pc_valid=0, halted=0.
  - FSM=BOOT.
  - Applies mid-operation regardless of any other input.
- FSM states: BOOT, RUN, HALTED. All updates are on the rising clk edge.
- BOOT:
  - Lasts exactly one cycle after reset deasserts.
  - pc holds RESET_ADDR, pc_valid=0, then -> RUN.
  - All other inputs ignored.
- RUN:
  - pc_valid=1.
  - Next-PC priority, highest first:
    1. exc_req: pc<=EXC_VECTOR, epc<=pc.
    2. branch_taken: pc<=branch_target.
    3. jump: pc<=jump_target.
    4. stall: pc unchanged.
    5. otherwise: pc<=pc+INC.
  - Misalignment: if the selected redirect target (branch or jump) has target mod INC != 0:
    - pc<=EXC_VECTOR, epc<=pc, misalign_err=1 for the next cycle only.
  - Redirects override stall. A taken branch while stall=1 still redirects.
  - halt_req (with no exc_req/branch_taken/jump):
    - pc holds, -> HALTED.
    - halt_req together with a redirect: redirect applies first, halt takes effect the following cycle if halt_req is still high.
  - halt_req with stall and no redirect: -> HALTED.
- HALTED:
  - halted=1, pc_valid=0, pc frozen.
  - branch_taken/jump/stall ignored.
  - exc_req: pc<=EXC_VECTOR, epc<=pc, -> RUN.
  - resume: -> RUN, pc unchanged. First valid fetch is the frozen pc.
  - resume and halt_req both high: stay HALTED.
- Arithmetic:
  - pc+INC wraps modulo 2^WIDTH. All-ones minus 3, +4 -> 0.
  - No overflow flag.
- misalign_err is registered and high for exactly one cycle per event.
  - Back-to-back events give back-to-back pulses.
- epc changes only on exception or misalignment entry.

Test Plan:
- Reset release, no inputs for 5 cycles:
  - pc = 0 (BOOT, pc_valid=0), then 0, 4, 8, 0xC with pc_valid=1.
- Running at pc=0x10, stall=1 for 2 cycles:
  - pc stays 0x10 for 2 cycles, then 0x14.
- At pc=0x20, branch_taken=1, branch_target=0x100, jump=1, jump_target=0x200 same cycle:
  - next pc=0x100.
  - Then at pc=0x104, exc_req=1 with branch_taken=1: pc=0x80, epc=0x104.
- At pc=0x40, jump=1, jump_target=0x202:
  - next pc=0x80, epc=0x40, misalign_err=1 for one cycle only.
- At pc=0x30, halt_req=1 for 1 cycle:
  - halted=1, pc_valid=0, pc=0x30 held for 3 cycles despite branch_taken pulses.
  - resume=1: next cycle pc_valid=1, pc=0x30, then 0x34.
- Reset asserted asynchronously mid-cycle at pc=0x58, held 7 ns:
  - pc=0 immediately (before the next edge), pc_valid=0.
  - After release: one BOOT cycle, then 0, 4.
- WIDTH=8, pc=0xFC, no inputs: next pc=0x00.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the IF stage: sequential fetch, branch/jump redirect,
// exception entry with EPC capture, misaligned-target trap and a halt/resume FSM.
`timescale 1ns/1ps

module pc_unit #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080),
    parameter int unsigned      INC        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             exc_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             pc_valid,
    output logic [WIDTH-1:0] epc,
    output logic             misalign_err,
    output logic             halted
);

    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             misalign_q, misalign_d;
    logic             pc_valid_q, pc_valid_d;
    logic             halted_q, halted_d;

    logic             redirect_s;
    logic [WIDTH-1:0] target_s;
    logic             target_bad_s;

    function automatic logic misaligned_f(input logic [WIDTH-1:0] addr);
        return (addr % INC_W) != ZERO_W;
    endfunction

    // Branch outranks jump when both are asserted.
    assign redirect_s   = branch_taken | jump;
    assign target_s     = branch_taken ? branch_target : jump_target;
    assign target_bad_s = misaligned_f(target_s);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect in the same cycle as halt_req defers the halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!exc_req && !redirect_s && halt_req) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (exc_req) begin
                    state_d = ST_RUN;
                end else if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Next-PC, EPC and status outputs.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    pc_d  = EXC_VECTOR;
                    epc_d = pc_q;
                end else if (redirect_s) begin
                    if (target_bad_s) begin
                        pc_d       = EXC_VECTOR;
                        epc_d      = pc_q;
                        misalign_d = 1'b1;
                    end else begin
                        pc_d = target_s;
                    end
                end else if (halt_req || stall) begin
                    pc_d = pc_q;
                end else begin
                    pc_d = pc_q + INC_W;
                end
            end
            ST_HALTED: begin
                if (exc_req) begin
                    pc_d  = EXC_VECTOR;
                    epc_d = pc_q;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
        pc_valid_d = (state_d == ST_RUN);
        halted_d   = (state_d == ST_HALTED);
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_ADDR;
            epc_q      <= ZERO_W;
            misalign_q <= 1'b0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
            pc_valid_q <= pc_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc_q + INC_W;
    assign pc_valid     = pc_valid_q;
    assign epc          = epc_q;
    assign misalign_err = misalign_q;
    assign halted       = halted_q;

    pc_unit_chk #(
        .WIDTH      (WIDTH),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc_q),
        .pc_valid     (pc_valid_q),
        .misalign_err (misalign_q),
        .halted       (halted_q)
    );

endmodule

// Invariants on the registered outputs.
module pc_unit_chk #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0080)
) (
    input logic             clk,
    input logic             reset,
    input logic [WIDTH-1:0] pc,
    input logic             pc_valid,
    input logic             misalign_err,
    input logic             halted
);

    a_halted_not_valid: assert property (@(posedge clk) disable iff (!reset)
        halted |-> !pc_valid);

    a_misalign_vector: assert property (@(posedge clk) disable iff (!reset)
        misalign_err |-> (pc == EXC_VECTOR));

endmodule

// File: tb/tb_pc_unit.sv
// Directed plan steps plus random traffic, checked each cycle against a
// rule-level reference model of the PC unit.
`timescale 1ns/1ps

module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, halt_req, resume, branch_taken, jump, exc_req;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_plus4, epc;
    logic        pc_valid, misalign_err, halted;

    logic        z1 = 1'b0;
    logic [7:0]  z8 = 8'h00;
    logic [7:0]  pc8, pcp8, epc8;
    logic        valid8, mis8, halted8;

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0=boot, 1=run, 2=halted
    logic [31:0] m_pc, m_epc;
    logic        m_mis;
    int          m_mode;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req), .resume(resume),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .exc_req(exc_req),
        .pc(pc), .pc_plus4(pc_plus4), .pc_valid(pc_valid), .epc(epc),
        .misalign_err(misalign_err), .halted(halted)
    );

    pc_unit #(.WIDTH(8), .RESET_ADDR(8'hF0), .EXC_VECTOR(8'h80), .INC(4)) dut8 (
        .clk(clk), .reset(reset), .stall(z1), .halt_req(z1), .resume(z1),
        .branch_taken(z1), .branch_target(z8), .jump(z1), .jump_target(z8),
        .exc_req(z1), .pc(pc8), .pc_plus4(pcp8), .pc_valid(valid8), .epc(epc8),
        .misalign_err(mis8), .halted(halted8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_mis = 1'b0; m_mode = 0;
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        m_mis = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (exc_req) begin
                m_epc = m_pc; m_pc = 32'h80;
            end else if (branch_taken || jump) begin
                tgt = branch_taken ? branch_target : jump_target;
                if ((tgt % 32'd4) != 32'd0) begin
                    m_epc = m_pc; m_pc = 32'h80; m_mis = 1'b1;
                end else begin
                    m_pc = tgt;
                end
            end else if (halt_req) begin
                m_mode = 2;
            end else if (!stall) begin
                m_pc = m_pc + 32'd4;
            end
        end else begin
            if (exc_req) begin
                m_epc = m_pc; m_pc = 32'h80; m_mode = 1;
            end else if (resume && !halt_req) begin
                m_mode = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".pc"},       pc,                  m_pc);
        chk({tag, ".pc_plus4"}, pc_plus4,            m_pc + 32'd4);
        chk({tag, ".pc_valid"}, 32'(pc_valid),       32'(m_mode == 1));
        chk({tag, ".halted"},   32'(halted),         32'(m_mode == 2));
        chk({tag, ".epc"},      epc,                 m_epc);
        chk({tag, ".misalign"}, 32'(misalign_err),   32'(m_mis));
    endtask

    task automatic idle();
        stall = 1'b0; halt_req = 1'b0; resume = 1'b0; branch_taken = 1'b0;
        jump = 1'b0; exc_req = 1'b0; branch_target = 32'h0; jump_target = 32'h0;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        chk("reset.pc_const", pc, 32'h0);
        reset = 1'b1;
        #1;
        compare_all("boot");
        chk("boot.valid_const", 32'(pc_valid), 32'h0);
        chk("boot.pc8", 32'(pc8), 32'hF0);

        step("run0"); chk("run0.pc_const", pc, 32'h0); chk("run0.valid_const", 32'(pc_valid), 32'h1);
        step("run1"); chk("run1.pc_const", pc, 32'h4);
        step("run2"); chk("run2.pc_const", pc, 32'h8);
        step("run3"); chk("run3.pc_const", pc, 32'hC);
        chk("w8.pc_fc", 32'(pc8), 32'hFC);
        chk("w8.plus4_wrap", 32'(pcp8), 32'h00);
        step("run4"); chk("run4.pc_const", pc, 32'h10);
        chk("w8.pc_wrap", 32'(pc8), 32'h00);
        chk("w8.valid", 32'(valid8), 32'h1);
        chk("w8.status", {29'h0, halted8, mis8, |epc8}, 32'h0);

        stall = 1'b1;
        step("stall0"); chk("stall0.pc_const", pc, 32'h10);
        step("stall1"); chk("stall1.pc_const", pc, 32'h10);
        stall = 1'b0;
        step("stall_end"); chk("stall_end.pc_const", pc, 32'h14);
        repeat (3) step("seq");
        chk("seq.pc_const", pc, 32'h20);

        branch_taken = 1'b1; branch_target = 32'h100; jump = 1'b1; jump_target = 32'h200;
        step("br_jp"); chk("br_jp.pc_const", pc, 32'h100);
        idle();
        step("seq104"); chk("seq104.pc_const", pc, 32'h104);
        exc_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h300;
        step("exc"); chk("exc.pc_const", pc, 32'h80); chk("exc.epc_const", epc, 32'h104);

        idle(); jump = 1'b1; jump_target = 32'h40;
        step("jp40"); chk("jp40.pc_const", pc, 32'h40);
        jump_target = 32'h202;
        step("mis"); chk("mis.pc_const", pc, 32'h80); chk("mis.epc_const", epc, 32'h40);
        chk("mis.flag_const", 32'(misalign_err), 32'h1);
        idle();
        step("mis_end"); chk("mis_end.flag_const", 32'(misalign_err), 32'h0);

        jump = 1'b1; jump_target = 32'h30;
        step("jp30");
        idle(); halt_req = 1'b1;
        step("halt"); chk("halt.halted_const", 32'(halted), 32'h1);
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i % 2 == 0); branch_target = 32'h500;
            step("held");
            chk("held.pc_const", pc, 32'h30);
            chk("held.valid_const", 32'(pc_valid), 32'h0);
        end
        idle(); resume = 1'b1; halt_req = 1'b1;
        step("res_and_halt"); chk("res_and_halt.halted_const", 32'(halted), 32'h1);
        halt_req = 1'b0;
        step("resume"); chk("resume.pc_const", pc, 32'h30); chk("resume.valid_const", 32'(pc_valid), 32'h1);
        idle();
        step("post_res"); chk("post_res.pc_const", pc, 32'h34);

        jump = 1'b1; jump_target = 32'h50; halt_req = 1'b1;
        step("jp_halt"); chk("jp_halt.pc_const", pc, 32'h50); chk("jp_halt.halted_const", 32'(halted), 32'h0);
        jump = 1'b0;
        step("deferred_halt"); chk("deferred_halt.halted_const", 32'(halted), 32'h1);
        halt_req = 1'b0; resume = 1'b1;
        step("resume2");
        idle(); jump = 1'b1; jump_target = 32'h58;
        step("jp58");
        idle();

        #1 reset = 1'b0;
        m_reset();
        #1;
        compare_all("async_rst");
        chk("async_rst.pc_const", pc, 32'h0);
        #6 reset = 1'b1;
        step("rst_run0"); chk("rst_run0.pc_const", pc, 32'h0);
        step("rst_run1"); chk("rst_run1.pc_const", pc, 32'h4);

        for (int i = 0; i < 400; i++) begin
            exc_req       = ($urandom_range(0, 19) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump          = ($urandom_range(0, 5) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            halt_req      = ($urandom_range(0, 9) == 0);
            resume        = ($urandom_range(0, 2) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            if ($urandom_range(0, 3) != 0) branch_target[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) jump_target[1:0] = 2'b00;
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
